// File: rtl/fp32_to_fp16_seq_if.sv
// Request/completion bundle for the binary32-to-binary16 narrowing converter.
`timescale 1ns/1ps
interface fp32_to_fp16_seq_if;
    logic        enb;
    logic [31:0] A;
    logic [15:0] C;
    logic        ack;

    modport master (output enb, output A, input C, input ack);
    modport slave  (input enb, input A, output C, output ack);
endinterface

// File: rtl/fp32_to_fp16_seq.sv
// Multi-cycle binary32 -> binary16 converter (RNE) with enb/ack handshake.
// Define FP16_SUBNORM_EN to emit binary16 subnormals; otherwise they flush to signed zero.
`timescale 1ns/1ps
module fp32_to_fp16_seq #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp32_to_fp16_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ROUND, S_DONE} state_t;
    typedef enum logic [2:0] {C_NAN, C_INF, C_ZERO, C_OVF, C_NORM, C_SUB, C_UNF} cls_t;

    state_t               r_state, w_next;
    logic                 w_accept;
    logic [IN_WIDTH-1:0]  r_a;
    logic                 r_sign;
    cls_t                 r_cls, w_cls;
    logic [22:0]          r_mant;
    logic [4:0]           r_exp5;
    logic [3:0]           r_shr;
    logic [9:0]           r_frac, w_frac;
    logic                 r_guard, r_sticky, w_guard, w_sticky;
    logic [OUT_WIDTH-1:0] r_c;
    logic [7:0]           w_exp8;
    logic [33:0]          w_ext;
    logic                 w_inc;
    logic [10:0]          w_sum;
    logic [15:0]          w_res;

    assign w_exp8 = r_a[30:23];

    always_comb begin
        if (w_exp8 == 8'hFF)       w_cls = (r_a[22:0] != '0) ? C_NAN : C_INF;
        else if (w_exp8 == 8'h00)  w_cls = C_ZERO;
        else if (w_exp8 > 8'd142)  w_cls = C_OVF;
        else if (w_exp8 >= 8'd113) w_cls = C_NORM;
        else if (w_exp8 >= 8'd102) w_cls = C_SUB;
        else                       w_cls = C_UNF;
    end

    // Subnormal shift of 14..24 is done as a 0..10 shift of the significand
    // pre-positioned 14 bits down, so frac/guard/sticky sit at fixed bit ranges.
    always_comb begin
        w_ext = {1'b1, r_mant, 10'b0} >> r_shr;
        if (r_cls == C_SUB) begin
            w_frac   = w_ext[33:24];
            w_guard  = w_ext[23];
            w_sticky = |w_ext[22:0];
        end else begin
            w_frac   = r_mant[22:13];
            w_guard  = r_mant[12];
            w_sticky = |r_mant[11:0];
        end
    end

    always_comb begin
        w_inc = r_guard & (r_sticky | r_frac[0]);
        w_sum = {1'b0, r_frac} + {10'b0, w_inc};
        w_res = {r_sign, 15'h0000};
        case (r_cls)
            C_NAN:        w_res = {r_sign, 5'h1F, 10'h200};
            C_INF, C_OVF: w_res = {r_sign, 5'h1F, 10'h000};
            // A carry out of the mantissa bumps the exponent; 30 -> 31 lands on Inf.
            C_NORM:       w_res = {r_sign, r_exp5 + {4'b0, w_sum[10]}, w_sum[9:0]};
            C_SUB: begin
                if (w_sum[10]) begin
                    w_res = {r_sign, 5'd1, 10'd0};
                end else begin
`ifdef FP16_SUBNORM_EN
                    w_res = {r_sign, 5'd0, w_sum[9:0]};
`else
                    w_res = {r_sign, 15'h0000};
`endif
                end
            end
            default:      w_res = {r_sign, 15'h0000};
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.enb) begin
                    w_next   = S_UNPACK;
                    w_accept = 1'b1;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_sign   <= 1'b0;
            r_cls    <= C_ZERO;
            r_mant   <= '0;
            r_exp5   <= '0;
            r_shr    <= '0;
            r_frac   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_c      <= '0;
        end else begin
            if (w_accept) r_a <= bus.A;
            case (r_state)
                S_UNPACK: begin
                    r_sign <= r_a[31];
                    r_mant <= r_a[22:0];
                    r_cls  <= w_cls;
                    r_exp5 <= 5'(w_exp8 - 8'd112);
                    r_shr  <= 4'(8'd112 - w_exp8);
                end
                S_ALIGN: begin
                    r_frac   <= w_frac;
                    r_guard  <= w_guard;
                    r_sticky <= w_sticky;
                end
                S_ROUND: r_c <= w_res;
                default: ;
            endcase
        end
    end

    assign bus.C   = r_c;
    assign bus.ack = (r_state == S_DONE);
endmodule
